fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write arbiter sharing one delayfifo write port among NREQ producers.
//  Grants one producer at a time for a burst of up to MAX_BURST beats or until req_last.
//  Passes the owner's beats to fifo_wr_en/fifo_wr_data and back-pressures on fifo_full.
//  Sits between the producer engines and the delayfifo instance in the capstone datapath.
// PARAMETERS
//  NREQ      4    number of requesters (>=2); grant_id width = $clog2(NREQ)
//  DBIT      513  beat width, matches delayfifo DBIT
//  MAX_BURST 4    max beats per grant (>=1); beat counter width = $clog2(MAX_BURST)+1
// PORTS
//  clk           in   1            clock, rising edge
//  rst           in   1            asynchronous reset, active-high
//  req_valid     in   NREQ         per-requester beat valid
//  req_last      in   NREQ         per-requester last beat of burst (sampled with valid)
//  req_data      in   NREQ*DBIT    beats; requester i at [i*DBIT +: DBIT]
//  req_ready     out  NREQ         beat accepted for requester i when valid&ready
//  fifo_full     in   1            delayfifo full flag
//  fifo_wr_en    out  1            delayfifo write enable
//  fifo_wr_data  out  DBIT         delayfifo write data
//  grant_id      out  $clog2(NREQ) current owner index (valid while busy)
//  busy          out  1            1 in BURST state
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, rr_ptr=0, owner=0, beat_cnt=0. Outputs: req_ready=0,
//    fifo_wr_en=0, fifo_wr_data=0, grant_id=0, busy=0. Reset mid-burst drops the burst;
//    beats already written stay in the FIFO.
//  - FSM: IDLE, BURST. All registers update on posedge clk only.
//  - IDLE: no beats accepted (req_ready=0, fifo_wr_en=0). If any req_valid: owner <= first
//    i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ; beat_cnt<=0; -> BURST.
//    1-cycle arbitration latency: request seen in cycle N, first beat earliest in N+1.
//  - BURST (combinational outputs from registered owner):
//    req_ready[owner] = !fifo_full; all other req_ready bits = 0.
//    fifo_wr_en = req_valid[owner] && !fifo_full; fifo_wr_data = req_data[owner slice].
//    Accepted beat = req_valid[owner] && !fifo_full. On accept: beat_cnt <= beat_cnt+1.
//    Release when accepted beat has req_last[owner]=1 OR beat_cnt==MAX_BURST-1:
//    -> IDLE, rr_ptr <= (owner+1) mod NREQ.
//  - fifo_full=1: no accept, beat_cnt/state unchanged; owner keeps grant indefinitely.
//  - Owner deasserts valid mid-burst: grant held, no timeout; resumes on next valid.
//  - Back-to-back bursts: one idle bubble cycle between release and next first beat.
//  - Fairness: each requester is granted within NREQ-1 other bursts of raising valid.
//  - req_last on a non-accepted cycle (stalled or non-owner) has no effect.
//  - Never writes while fifo_full=1; no overflow is possible from this block.
//  - grant_id = owner; busy = (state==BURST). In IDLE fifo_wr_data = 0.
// TESTING
//  1 Reset: rst=1 mid-BURST -> same cycle busy=0, fifo_wr_en=0, req_ready=0; after
//    release, req_valid=4'b0100 -> grant_id=2 one cycle later.
//  2 Round robin: req_valid=4'b1111, each burst 1 beat with last=1 -> grants 0,1,2,3,0
//    with one bubble cycle between beats (8 cycles per 4 beats).
//  3 Burst cap: req 1 valid, last=0 forever, MAX_BURST=4 -> exactly 4 beats written,
//    then IDLE; next grant picks req 2 if valid, else req 1 again.
//  4 Full stall: fifo_full=1 for 3 cycles mid-burst -> fifo_wr_en=0, req_ready=0, beat_cnt
//    held; after full drops, remaining beats written in order, no beat lost/duplicated.
//  5 Data routing: req i sends data = {i, beat index} -> FIFO content order matches
//    grant order; no other requester's data appears while grant_id=i.
//  6 Early last: owner 3 sends 2 beats, last on beat 2 -> release, rr_ptr=0, busy=0
//    next cycle; a valid owner drop between beats keeps grant_id=3.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one delayfifo write port among NREQ producers.
// A grant lasts until the owner's req_last beat or MAX_BURST accepted beats.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DBIT      = 513,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_last,
  input  logic [NREQ*DBIT-1:0]    req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [DBIT-1:0]         fifo_wr_data,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
);

  localparam int IDW  = $clog2(NREQ);
  localparam int IDW1 = IDW + 1;
  localparam int CW   = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state_reg;
  logic [IDW-1:0] rr_ptr_reg;
  logic [IDW-1:0] owner_reg;
  logic [CW-1:0]  beat_cnt_reg;

  logic [DBIT-1:0]   data_arr [NREQ];
  logic [DBIT-1:0]   owner_data;
  logic [2*NREQ-1:0] rot_full;
  logic [NREQ-1:0]   rot_valid;
  logic              found;
  logic [IDW1-1:0]   offset;
  logic [IDW1-1:0]   sum;
  logic [IDW-1:0]    pick;
  logic [IDW-1:0]    next_ptr;
  logic              in_burst;
  logic              accept;
  logic              release_now;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign data_arr[gi]  = req_data[gi*DBIT +: DBIT];
      assign req_ready[gi] = in_burst && (owner_reg == IDW'(gi)) && !fifo_full;
    end
  endgenerate

  // Rotate valids so bit 0 is the requester at rr_ptr; lowest set bit wins.
  assign rot_full  = {req_valid, req_valid} >> rr_ptr_reg;
  assign rot_valid = rot_full[NREQ-1:0];
  assign found     = |rot_valid;

  always_comb begin
    offset = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) offset = IDW1'(k);
    end
    sum = {1'b0, rr_ptr_reg} + offset;
    if (sum >= IDW1'(NREQ)) sum = sum - IDW1'(NREQ);
    pick = sum[IDW-1:0];
  end

  assign in_burst     = (state_reg == BURST);
  assign owner_data   = data_arr[owner_reg];
  assign accept       = in_burst && req_valid[owner_reg] && !fifo_full;
  assign release_now  = accept && (req_last[owner_reg] || (beat_cnt_reg == CW'(MAX_BURST - 1)));
  assign next_ptr     = (owner_reg == IDW'(NREQ - 1)) ? '0 : owner_reg + 1'b1;

  assign fifo_wr_en   = accept;
  assign fifo_wr_data = in_burst ? owner_data : '0;
  assign grant_id     = owner_reg;
  assign busy         = in_burst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      owner_reg    <= '0;
      beat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            owner_reg    <= pick;
            beat_cnt_reg <= '0;
            state_reg    <= BURST;
          end
        end
        BURST: begin
          // Stalls (full or owner not valid) hold everything, grant included.
          if (accept) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
            if (release_now) begin
              state_reg  <= IDLE;
              rr_ptr_reg <= next_ptr;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus a randomized run
// checked against a burst-level reference model.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DBIT      = 513;
  localparam int MAX_BURST = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_last  = '0;
  logic [NREQ*DBIT-1:0] req_data  = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 fifo_full = 1'b0;
  logic                 fifo_wr_en;
  logic [DBIT-1:0]      fifo_wr_data;
  logic [1:0]           grant_id;
  logic                 busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: burst-level view of who owns the port.
  bit m_busy;
  int m_owner, m_cnt, m_ptr;
  int beat_idx [NREQ];
  logic [DBIT-1:0] act_q[$];
  logic [DBIT-1:0] exp_q[$];

  fifo_wr_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1);
  end

  function automatic logic [DBIT-1:0] mk_data(int i, int b);
    logic [DBIT-1:0] d;
    logic [31:0] tag;
    tag = $urandom;
    d = '0;
    d[15:0] = b[15:0];
    d[23:16] = i[7:0];
    d[DBIT-2 -: 32] = tag;
    d[DBIT-1] = i[0];
    return d;
  endfunction

  task automatic refresh_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DBIT +: DBIT] = mk_data(i, beat_idx[i]);
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_last = '0; fifo_full = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NREQ; i++) beat_idx[i] = 0;
    act_q.delete(); exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    refresh_data();
  endtask

  // One clock: log DUT writes, advance the model and producers, land on negedge.
  task automatic tick();
    #1;
    if (fifo_wr_en) begin
      act_q.push_back(fifo_wr_data);
      $display("t=%0t write req=%0d beat=%0d", $time, fifo_wr_data[23:16], fifo_wr_data[15:0]);
    end
    if (m_busy) begin
      if (req_valid[m_owner] && !fifo_full) begin
        exp_q.push_back(req_data[m_owner*DBIT +: DBIT]);
        m_cnt++;
        if (req_last[m_owner] || m_cnt == MAX_BURST) begin
          m_busy = 0;
          m_ptr = (m_owner + 1) % NREQ;
        end
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (!m_busy && req_valid[(m_ptr + k) % NREQ]) begin
          m_busy = 1; m_owner = (m_ptr + k) % NREQ; m_cnt = 0;
        end
      end
    end
    for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) beat_idx[i]++;
    @(posedge clk);
    @(negedge clk);
    refresh_data();
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en: got %b want 0", fifo_wr_en); end
    n_cmp++; if (req_ready !== 4'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL rst_grant: got %0d want 0", grant_id); end
    n_cmp++; if (fifo_wr_data !== '0) begin n_bad++; $display("FAIL rst_data: got %0h want 0", fifo_wr_data); end
    do_reset();
    req_valid = 4'b0001;
    tick();
    #1;
    n_cmp++; if (busy !== 1'b1 || grant_id !== 2'd0 || fifo_wr_en !== 1'b1) begin
      n_bad++; $display("FAIL first_grant: got busy=%b id=%0d en=%b want 1/0/1", busy, grant_id, fifo_wr_en);
    end
    tick();
    rst = 1'b1;
    #1;
    model_reset();
    n_cmp++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || req_ready !== 4'b0) begin
      n_bad++; $display("FAIL midburst_rst: got busy=%b en=%b rdy=%b want 0/0/0000", busy, fifo_wr_en, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0100;
    tick();
    #1;
    n_cmp++; if (busy !== 1'b1 || grant_id !== 2'd2) begin
      n_bad++; $display("FAIL post_rst_grant: got busy=%b id=%0d want 1/2", busy, grant_id);
    end
    req_last = 4'b0100;
    tick();
    req_valid = '0; req_last = '0;
    tick();
    n_cmp++; if (act_q.size() != 2 || exp_q.size() != 2) begin
      n_bad++; $display("FAIL rst_writes: got %0d want 2 (model %0d)", act_q.size(), exp_q.size());
    end else if (act_q[0] !== exp_q[0] || act_q[1] !== exp_q[1]) begin
      n_bad++; $display("FAIL rst_write_data: got %0h want %0h", act_q[1], exp_q[1]);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_cmp++; if (fifo_wr_en !== ((c % 2) == 1)) begin
        n_bad++; $display("FAIL rr_bubble c=%0d: got %b want %b", c, fifo_wr_en, (c % 2) == 1);
      end
      tick();
    end
    req_valid = '0; req_last = '0;
    n_cmp++; if (act_q.size() != 5) begin
      n_bad++; $display("FAIL rr_count: got %0d want 5", act_q.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        n_cmp++; if (act_q[j][23:16] !== 8'(j % NREQ)) begin
          n_bad++; $display("FAIL rr_order j=%0d: got %0d want %0d", j, act_q[j][23:16], j % NREQ);
        end
      end
    end
  endtask

  task automatic test_burst_cap();
    do_reset();
    req_valid = 4'b0010;
    tick();
    for (int b = 0; b < MAX_BURST; b++) begin
      #1;
      n_cmp++; if (fifo_wr_en !== 1'b1 || grant_id !== 2'd1) begin
        n_bad++; $display("FAIL cap_beat b=%0d: got en=%b id=%0d want 1/1", b, fifo_wr_en, grant_id);
      end
      tick();
    end
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cap_release: got busy=%b want 0", busy); end
    req_valid = 4'b0110;
    tick();
    #1;
    n_cmp++; if (grant_id !== 2'd2) begin n_bad++; $display("FAIL cap_next_rr: got %0d want 2", grant_id); end
    req_valid = 4'b0100; req_last = 4'b0100;
    tick();
    req_valid = 4'b0010; req_last = '0;
    tick();
    #1;
    n_cmp++; if (grant_id !== 2'd1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL cap_regrant: got id=%0d busy=%b want 1/1", grant_id, busy);
    end
    req_last = 4'b0010;
    tick();
    req_valid = '0; req_last = '0;
    tick();
    n_cmp++; if (act_q.size() != 6) begin
      n_bad++; $display("FAIL cap_count: got %0d want 6", act_q.size());
    end else begin
      for (int j = 0; j < MAX_BURST; j++) begin
        n_cmp++; if (act_q[j][23:0] !== {8'd1, 16'(j)}) begin
          n_bad++; $display("FAIL cap_data j=%0d: got %0h want %0h", j, act_q[j][23:0], {8'd1, 16'(j)});
        end
      end
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    req_valid = 4'b0001;
    tick(); tick(); tick();
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b1) begin
        n_bad++; $display("FAIL stall c=%0d: got en=%b rdy=%b busy=%b want 0/0000/1", c, fifo_wr_en, req_ready, busy);
      end
      tick();
    end
    fifo_full = 1'b0;
    tick(); tick();
    req_valid = '0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stall_release: got busy=%b want 0", busy); end
    n_cmp++; if (act_q.size() != 4) begin
      n_bad++; $display("FAIL stall_count: got %0d want 4", act_q.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_cmp++; if (act_q[j][15:0] !== 16'(j)) begin
          n_bad++; $display("FAIL stall_order j=%0d: got %0d want %0d", j, act_q[j][15:0], j);
        end
      end
    end
  endtask

  task automatic test_early_last();
    do_reset();
    req_valid = 4'b1000;
    tick(); tick();
    req_valid = '0;
    #1;
    n_cmp++; if (grant_id !== 2'd3 || fifo_wr_en !== 1'b0 || req_ready !== 4'b1000) begin
      n_bad++; $display("FAIL hold_grant: got id=%0d en=%b rdy=%b want 3/0/1000", grant_id, fifo_wr_en, req_ready);
    end
    tick();
    req_valid = 4'b1000; req_last = 4'b1000;
    #1;
    n_cmp++; if (fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL last_beat: got en=%b want 1", fifo_wr_en); end
    tick();
    req_valid = 4'b1111; req_last = '0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL early_release: got busy=%b want 0", busy); end
    tick();
    #1;
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL wrap_ptr: got %0d want 0", grant_id); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] exp_rdy;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom);
      req_last  = 4'($urandom) & 4'($urandom);
      fifo_full = ($urandom_range(0, 4) == 0);
      #1;
      exp_rdy = (m_busy && !fifo_full) ? 4'(1 << m_owner) : 4'b0;
      n_cmp++; if (busy !== m_busy) begin n_bad++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy, m_busy); end
      if (m_busy) begin
        n_cmp++; if (grant_id !== 2'(m_owner)) begin n_bad++; $display("FAIL rnd_grant c=%0d: got %0d want %0d", c, grant_id, m_owner); end
      end
      n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, req_ready, exp_rdy); end
      n_cmp++; if (fifo_wr_en !== (m_busy && req_valid[m_owner] && !fifo_full)) begin
        n_bad++; $display("FAIL rnd_wr_en c=%0d: got %b want %b", c, fifo_wr_en, m_busy && req_valid[m_owner] && !fifo_full);
      end
      n_cmp++; if (fifo_wr_data !== (m_busy ? req_data[m_owner*DBIT +: DBIT] : '0)) begin
        n_bad++; $display("FAIL rnd_data c=%0d: got %0h", c, fifo_wr_data);
      end
      tick();
    end
    n_cmp++; if (act_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL rnd_count: got %0d want %0d", act_q.size(), exp_q.size());
    end else begin
      for (int j = 0; j < act_q.size(); j++) begin
        if (act_q[j] !== exp_q[j]) begin
          n_cmp++; n_bad++; $display("FAIL rnd_seq j=%0d: got %0h want %0h", j, act_q[j], exp_q[j]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < NREQ; i++) beat_idx[i] = 0;
    test_reset();
    test_round_robin();
    test_burst_cap();
    test_full_stall();
    test_early_last();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
